csa_accum_resolve: RTL and testbench

Streaming accumulator that is the consumer side of the team's carry-save adder path: it absorbs a packet of unsigned operands into a redundant sum/carry pair and converts that pair back to a plain binary sum. Each accepted word costs one carry-save step with no carry propagation. On the packet's last word the block runs a chunked ripple-carry conversion and presents the binary result with an overflow flag. It sits downstream of operand producers and upstream of any block that needs a non-redundant sum.

---
 rtl/csa_accum_resolve.sv | 123 ++++++++++++
 tb/tb_csa_accum_resolve.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_resolve.sv
// Carry-save packet accumulator with chunked ripple resolve; result WIDTH/CHUNK edges after last accept, in_ready low outside ACC.
// Output held until out_ready. Define CSA_RES_SATURATE_EN to clamp out_sum to all ones on overflow.
module csa_accum_resolve #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] s, s_n;
    logic [WIDTH-1:0] c, c_n;
    logic [WIDTH-1:0] cfull;
    logic             ovf, ovf_n;
    logic             rc, rc_n;
    logic [KW-1:0]    k, k_n;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] out_sum_n;
    logic             out_ovf_n;
    logic             in_ready_n;
    logic             out_valid_n;
    int               base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            s         <= '0;
            c         <= '0;
            ovf       <= 1'b0;
            rc        <= 1'b0;
            k         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            c         <= c_n;
            ovf       <= ovf_n;
            rc        <= rc_n;
            k         <= k_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_sum   <= out_sum_n;
            out_ovf   <= out_ovf_n;
        end
    end

    always_comb begin
        state_n   = state;
        s_n       = s;
        c_n       = c;
        ovf_n     = ovf;
        rc_n      = rc;
        k_n       = k;
        out_sum_n = out_sum;
        out_ovf_n = out_ovf;

        cfull = (s & c) | (s & in_data) | (c & in_data);
        base  = int'(k) * CHUNK;
        csum  = {1'b0, s[base +: CHUNK]} + {1'b0, c[base +: CHUNK]} + {{CHUNK{1'b0}}, rc};

        case (state)
            ACC: begin
                if (in_valid && in_ready) begin
                    s_n = s ^ c ^ in_data;
                    c_n = {cfull[WIDTH-2:0], 1'b0};
                    // The carry shifted out of the top bit is a wrap of the true sum.
                    ovf_n = ovf | cfull[WIDTH-1];
                    if (in_last) begin
                        state_n = RESOLVE;
                        k_n     = '0;
                        rc_n    = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                s_n[base +: CHUNK] = csum[CHUNK-1:0];
                rc_n = csum[CHUNK];
                k_n  = k + 1'b1;
                if (k == K_LAST) begin
                    ovf_n     = ovf | csum[CHUNK];
                    state_n   = OUT;
                    out_ovf_n = ovf_n;
`ifdef CSA_RES_SATURATE_EN
                    out_sum_n = ovf_n ? '1 : s_n;
`else
                    out_sum_n = s_n;
`endif
                end
            end
            OUT: begin
                if (out_ready) begin
                    s_n     = '0;
                    c_n     = '0;
                    ovf_n   = 1'b0;
                    state_n = ACC;
                end
            end
            default: state_n = ACC;
        endcase

        in_ready_n  = (state_n == ACC);
        out_valid_n = (state_n == OUT);
    end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Randomised and directed bench for csa_accum_resolve against an integer-sum model.
module tb_csa_accum_resolve;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    int         gap[$];

    always #5 clk = ~clk;

    csa_accum_resolve #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives pkt (with optional idle gaps between words) until every word is accepted.
    task automatic send_words();
        for (int i = 0; i < pkt.size(); i++) begin
            bit acc = 1'b0;
            int t = 0;
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == pkt.size() - 1);
            while (!acc && t < 50) begin
                acc = in_ready;
                tick();
                t++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL accept_timeout word %0d: in_ready=%0b required 1", i, in_ready);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i < pkt.size() - 1 && i < gap.size())
                for (int g = 0; g < gap[i]; g++) tick();
        end
    endtask

    // Checks latency, result and handshake for the packet in pkt; holds out_ready low for hold cycles.
    task automatic check_result(input string name, input int hold);
        int total = 0;
        int lat = 0;
        logic [7:0] exp_sum;
        logic exp_ovf;
        foreach (pkt[i]) total += int'(pkt[i]);
        exp_ovf = (total >= 256);
`ifdef CSA_RES_SATURATE_EN
        exp_sum = exp_ovf ? 8'hFF : 8'(total % 256);
`else
        exp_sum = 8'(total % 256);
`endif
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required 2", name, lat);
        end
        out_ready = (hold == 0);
        checks++;
        if (out_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s sum: got %02h required %02h", name, out_sum, exp_sum);
        end
        checks++;
        if (out_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %0b required %0b", name, out_ovf, exp_ovf);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_in_out: got %0b required 0", name, in_ready);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== exp_sum || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold %0d: valid=%0b sum=%02h in_ready=%0b required 1 %02h 0",
                         name, h, out_valid, out_sum, in_ready, exp_sum);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'h00 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b in_ready=%0b sum=%02h ovf=%0b required 0 1 00 0",
                     out_valid, in_ready, out_sum, out_ovf);
        end
    endtask

    task automatic test_basic();
        pkt = '{8'h0D, 8'h01, 8'h08}; gap = {};
        send_words();
        check_result("basic", 0);
    endtask

    task automatic test_overflow();
        pkt = '{8'hFF, 8'h01}; gap = {};
        send_words();
        check_result("overflow", 0);
        pkt = '{8'hFF, 8'hFF, 8'hFF, 8'h03}; gap = {};
        send_words();
        check_result("multi_wrap", 1);
    endtask

    task automatic test_multi_word();
        pkt = '{8'h0B, 8'h0A, 8'h0F}; gap = {};
        send_words();
        check_result("multi_word", 0);
        pkt = '{8'h5A}; gap = {};
        send_words();
        check_result("single_word", 0);
    endtask

    task automatic test_backpressure();
        pkt = '{8'h81, 8'h07}; gap = {};
        send_words();
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        check_result("backpressure", 5);
        pkt = '{8'h33}; gap = {};
        send_words();
        check_result("after_backpressure", 0);
    endtask

    task automatic test_reset_mid_resolve();
        pkt = '{8'h11, 8'h22}; gap = {};
        send_words();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_resolve: valid=%0b in_ready=%0b sum=%02h required 0 1 00",
                     out_valid, in_ready, out_sum);
        end
        pkt = '{8'h02, 8'h03}; gap = {};
        send_words();
        check_result("after_reset", 0);
    endtask

    task automatic test_reset_in_out();
        int t = 0;
        pkt = '{8'h44, 8'hF0}; gap = {};
        out_ready = 1'b0;
        send_words();
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_out: valid=%0b in_ready=%0b ovf=%0b required 0 1 0",
                     out_valid, in_ready, out_ovf);
        end
        pkt = '{8'h01}; gap = {};
        send_words();
        check_result("after_out_reset", 0);
    endtask

    task automatic test_gapped();
        pkt = '{8'h10, 8'h20}; gap = '{3, 0};
        send_words();
        check_result("gapped", 0);
    endtask

    task automatic test_back_to_back_random();
        for (int p = 0; p < 25; p++) begin
            int n = $urandom_range(1, 6);
            pkt = {}; gap = {};
            for (int i = 0; i < n; i++) begin
                pkt.push_back(8'($urandom_range(0, 255)));
                gap.push_back((p % 3 == 0) ? $urandom_range(0, 2) : 0);
            end
            send_words();
            check_result("random", (p % 4 == 1) ? $urandom_range(1, 3) : 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_multi_word();
        test_backpressure();
        test_reset_mid_resolve();
        test_reset_in_out();
        test_gapped();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
